// File: rtl/ofmap_wb.sv
// Output-feature-map write-back: takes one 8-lane psum beat, applies ReLU/saturation
// per lane and serialises the lanes onto a single memory write port with generated addresses.
module ofmap_wb #(
  parameter int K           = 4,
  parameter int Orow        = 8,
  parameter int Ocol        = 8,
  parameter int Sample_area = 16384,
  parameter int Base        = 0,
  parameter int PW          = 24,
  parameter int OW          = 16,
  parameter int RELU        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*PW-1:0]   in_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [19:0]       wr_addr,
  output logic [OW-1:0]     wr_data,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int KW = (K    > 1) ? $clog2(K)    : 1;
  localparam int RW = (Orow > 1) ? $clog2(Orow) : 1;
  localparam int CW = (Ocol > 1) ? $clog2(Ocol) : 1;

  // Saturation bounds held at input width; assumes PW > OW.
  localparam logic signed [PW-1:0] SAT_HI = PW'({(OW-1){1'b1}});
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  logic [1:0]       state;
  logic [2:0]       lane;
  logic [KW-1:0]    k;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [8*PW-1:0]  hold;

  logic             last_col, last_row, last_k, last_beat;
  logic [19:0]      addr;
  logic signed [PW-1:0] v_raw, v_relu;
  logic [OW-1:0]    v_sat;

  assign last_col  = (col == CW'(Ocol - 1));
  assign last_row  = (row == RW'(Orow - 1));
  assign last_k    = (k   == KW'(K - 1));
  assign last_beat = last_col && last_row && last_k;

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
      k     <= '0;
      row   <= '0;
      col   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            lane  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_ready) begin
            lane <= lane + 1'b1;
            if (lane == 3'd7) begin
              if (last_beat) begin
                state <= DONE;
              end else begin
                state <= IDLE;
                if (last_col) begin
                  col <= '0;
                  if (last_row) begin
                    row <= '0;
                    k   <= k + 1'b1;
                  end else begin
                    row <= row + 1'b1;
                  end
                end else begin
                  col <= col + 1'b1;
                end
              end
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Modular arithmetic commutes with + and *, so 20-bit math equals full precision truncated.
  assign addr = 20'(Base)
              + 20'(lane) * 20'(Sample_area)
              + 20'(k)    * 20'(Orow * Ocol)
              + 20'(row)  * 20'(Ocol)
              + 20'(col);

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    v_raw  = hold[32'(lane)*PW +: PW];
    v_relu = v_raw;
    v_sat  = v_raw[OW-1:0];
    if (RELU != 0 && v_raw < 0) v_relu = '0;
    if (v_relu > SAT_HI)      v_sat = SAT_HI[OW-1:0];
    else if (v_relu < SAT_LO) v_sat = SAT_LO[OW-1:0];
    else                      v_sat = v_relu[OW-1:0];
  end

  assign in_ready = (state == IDLE) && !rst;
  assign wr_en    = (state == DRAIN);
  assign done     = (state == DONE);
  assign wr_addr  = wr_en ? addr  : '0;
  assign wr_data  = wr_en ? v_sat : '0;

endmodule

// File: tb/tb_ofmap_wb.sv
// Self-checking bench for ofmap_wb: two instances (a small multi-beat tensor and a one-beat
// tensor) driven with random beats and compared against a scoreboard of expected writes.
module tb_ofmap_wb;
  localparam int PW = 24;
  localparam int OW = 16;

  localparam int P_K    [2] = '{2, 1};
  localparam int P_OROW [2] = '{2, 1};
  localparam int P_OCOL [2] = '{3, 1};
  localparam int P_SA   [2] = '{'h40, 'h40};
  localparam int P_BASE [2] = '{0, 'h100};
  localparam int P_RELU [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, in_valid, wr_ready;
  logic [8*PW-1:0]  in_data [2];
  wire  [1:0]       in_ready, wr_en, done;
  wire  [19:0]      wr_addr [2];
  wire  [OW-1:0]    wr_data [2];

  ofmap_wb #(.K(P_K[0]), .Orow(P_OROW[0]), .Ocol(P_OCOL[0]), .Sample_area(P_SA[0]),
             .Base(P_BASE[0]), .PW(PW), .OW(OW), .RELU(P_RELU[0])) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .wr_en(wr_en[0]), .wr_ready(wr_ready[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .done(done[0]));

  ofmap_wb #(.K(P_K[1]), .Orow(P_OROW[1]), .Ocol(P_OCOL[1]), .Sample_area(P_SA[1]),
             .Base(P_BASE[1]), .PW(PW), .OW(OW), .RELU(P_RELU[1])) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .wr_en(wr_en[1]), .wr_ready(wr_ready[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .done(done[1]));

  typedef struct {
    int inst;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_wr   [2] = '{0, 0};
  int  m_beat [2] = '{0, 0};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int post(input int v, input bit relu);
    int r;
    r = v;
    if (relu && r < 0) r = 0;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic logic [8*PW-1:0] random_beat();
    logic [8*PW-1:0] d;
    int v;
    for (int l = 0; l < 8; l++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom);
      else                           v = int'($urandom_range(0, 80000)) - 40000;
      d[l*PW +: PW] = PW'(v);
    end
    return d;
  endfunction

  function automatic logic [8*PW-1:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                             input int v4, input int v5, input int v6, input int v7);
    logic [8*PW-1:0] d;
    d = {PW'(v7), PW'(v6), PW'(v5), PW'(v4), PW'(v3), PW'(v2), PW'(v1), PW'(v0)};
    return d;
  endfunction

  // Expected writes for the next beat of instance i, from the tensor position of that beat.
  task automatic push_beat(input int i, input logic [8*PW-1:0] d);
    logic signed [PW-1:0] lv;
    wr_t e;
    int b, plane, kk, rr, cc;
    b     = m_beat[i];
    plane = P_OROW[i] * P_OCOL[i];
    kk    = b / plane;
    rr    = (b / P_OCOL[i]) % P_OROW[i];
    cc    = b % P_OCOL[i];
    for (int l = 0; l < 8; l++) begin
      lv     = d[l*PW +: PW];
      e.inst = i;
      e.addr = (P_BASE[i] + l*P_SA[i] + kk*plane + rr*P_OCOL[i] + cc) & 'hFFFFF;
      e.data = post(int'(lv), P_RELU[i] != 0);
      exp_q.push_back(e);
    end
    m_beat[i]++;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i] && wr_ready[i] && !rst[i]) begin
        wr_t e;
        n_wr[i]++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", i, -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_inst", i, e.inst);
          check("wr_addr", wr_addr[i], e.addr);
          check("wr_data", $signed(wr_data[i]), e.data);
        end
      end
    end
  end

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    tick();
    rst[i] = 1'b0;
    #1;
    m_beat[i] = 0;
  endtask

  // One beat: accept, then drain with optional stall at stall_lane or reset at rst_lane.
  task automatic beat(input int i, input logic [8*PW-1:0] d, input bit hold,
                      input int stall_lane, input int stall_len, input int rst_lane,
                      output int cycles);
    int t, writes, stalled;
    logic [19:0]   sa;
    logic [OW-1:0] sd;
    cycles  = 0;
    writes  = 0;
    stalled = 0;
    sa = '0;
    sd = '0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    t = 0;
    while (!in_ready[i] && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready[i]) begin
      check("accept_timeout", 0, 1);
      in_valid[i] = 1'b0;
      return;
    end
    push_beat(i, d);
    tick();
    cycles = 1;
    check("wr_en_latency", wr_en[i], 1);
    if (hold) in_data[i] = random_beat();
    else      in_valid[i] = 1'b0;
    t = 0;
    while (!in_ready[i] && !done[i] && t < 200) begin
      if (writes == rst_lane) begin
        rst[i] = 1'b1;
        wr_ready[i] = 1'b0;
        tick();
        check("rst_wr_en", wr_en[i], 0);
        check("rst_in_ready", in_ready[i], 0);
        check("rst_wr_addr", wr_addr[i], 0);
        check("rst_done", done[i], 0);
        rst[i] = 1'b0;
        wr_ready[i] = 1'b1;
        in_valid[i] = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready[i], 1);
        exp_q.delete();
        m_beat[i] = 0;
        return;
      end
      if (writes == stall_lane && stall_len > 0) begin
        if (stalled == 0) begin
          sa = wr_addr[i];
          sd = wr_data[i];
        end else begin
          check("stall_addr", wr_addr[i], sa);
          check("stall_data", wr_data[i], sd);
        end
        wr_ready[i] = (stalled < stall_len) ? 1'b0 : 1'b1;
        stalled++;
      end else begin
        wr_ready[i] = 1'b1;
      end
      if (wr_en[i] && wr_ready[i]) writes++;
      tick();
      cycles++;
      t++;
    end
    wr_ready[i] = 1'b1;
    check("drain_timeout", (t < 200) ? 1 : 0, 1);
    check("beat_writes", writes, 8);
  endtask

  initial begin
    int cyc;
    logic [8*PW-1:0] sat_beat;
    rst      = 2'b11;
    in_valid = 2'b00;
    wr_ready = 2'b11;
    in_data[0] = '0;
    in_data[1] = '0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", in_ready[i], 0);
      check("reset_wr_en", wr_en[i], 0);
      check("reset_done", done[i], 0);
      check("reset_wr_addr", wr_addr[i], 0);
      check("reset_wr_data", wr_data[i], 0);
    end
    rst = 2'b00;
    #1;
    for (int i = 0; i < 2; i++) check("release_in_ready", in_ready[i], 1);

    // Minimal tensor: lanes 1..8 at Base + lane*Sample_area.
    beat(1, pack8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, -1, 0, -1, cyc);
    check("min_done_cycles", cyc, 9);
    check("min_done", done[1], 1);

    sat_beat = pack8(40000, -40000, -5, 32767, -32768, 0, 100000, -1);

    // Saturation with ReLU enabled.
    do_reset(1);
    beat(1, sat_beat, 1'b0, -1, 0, -1, cyc);
    check("relu_done", done[1], 1);

    // Saturation with ReLU disabled, then the full counter-wrap tensor.
    beat(0, sat_beat, 1'b0, -1, 0, -1, cyc);
    check("sat_beat_cycles", cyc, 9);
    beat(0, random_beat(), 1'b0, 2, 3, -1, cyc);
    check("stall_beat_cycles", cyc, 12);
    for (int b = 2; b < 12; b++) begin
      beat(0, random_beat(), 1'b1, -1, 0, -1, cyc);
      check("held_beat_cycles", cyc, 9);
    end
    check("wrap_done", done[0], 1);
    check("wrap_total_writes", n_wr[0], 96);
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("done_in_ready", in_ready[0], 0);
      check("done_wr_en", wr_en[0], 0);
      check("done_sticky", done[0], 1);
    end
    in_valid[0] = 1'b0;

    // Reset while lane 4 is pending, then a fresh beat from Base.
    do_reset(1);
    beat(1, random_beat(), 1'b0, -1, 0, 4, cyc);
    beat(1, random_beat(), 1'b0, -1, 0, -1, cyc);
    check("after_rst_cycles", cyc, 9);
    check("after_rst_done", done[1], 1);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
